// File: rtl/proc_ctrl_regs.sv
// proc_ctrl_regs
//   Processor state registers: PSR flags, program counter, instruction
//   register, link register and an interrupt shadow (EPC/EPSR) used for a
//   single, non-nesting interrupt level.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   C_in, L_in, F_in, Z_in, N_in    ALU flag results
//   cmp_f_en / of_f_en / z_f_en     group write enables (L,N / C,F / Z)
//   pc_en, pc_sel                   pc update: 00 inc, 01 branch rel, 10 jump, 11 hold
//   branch_disp                     signed displacement for relative branch
//   jump_addr                       absolute jump target
//   link_en                         with pc_en, capture pc+1 into link
//   instr_en, instr_in              instruction register load
//   irq_take, rti                   interrupt entry / return pulses
//   psr                             {int_active, 7'b0, N, Z, F, 2'b0, L, 1'b0, C}
//   instr, pc, link, epc            register outputs
module proc_ctrl_regs #(
  parameter int PC_WIDTH = 21,
  parameter int INSTR_WIDTH = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned IRQ_VECTOR = 'h100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   C_in,
  input  logic                   L_in,
  input  logic                   F_in,
  input  logic                   Z_in,
  input  logic                   N_in,
  input  logic                   cmp_f_en,
  input  logic                   of_f_en,
  input  logic                   z_f_en,
  input  logic                   pc_en,
  input  logic [1:0]             pc_sel,
  input  logic [15:0]            branch_disp,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  input  logic                   link_en,
  input  logic                   instr_en,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   irq_take,
  input  logic                   rti,
  output logic [15:0]            psr,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    link,
  output logic [PC_WIDTH-1:0]    epc
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] IRQ_PC     = PC_WIDTH'(IRQ_VECTOR);

  typedef enum logic {
    ST_RUN,
    ST_IRQ
  } state_t;

  state_t state, state_next;

  // Flags are held packed as {N, Z, F, L, C}; psr is assembled from them.
  logic [4:0] flags, flags_next, flags_wr;
  logic [4:0] epsr, epsr_next;
  logic [PC_WIDTH-1:0] pc_next, link_next, epc_next;
  logic [PC_WIDTH-1:0] pc_inc, pc_branch;
  logic [PC_WIDTH+15:0] disp_ext;
  logic [INSTR_WIDTH-1:0] instr_next;
  logic int_active, irq_entry, rti_act;

  assign int_active = (state == ST_IRQ);
  assign psr = {int_active, 7'b0, flags[4], flags[3], flags[2], 2'b0, flags[1], 1'b0, flags[0]};

  // Extended wider than pc, then truncated, so any PC_WIDTH works.
  assign disp_ext  = {{PC_WIDTH{branch_disp[15]}}, branch_disp};
  assign pc_inc    = pc + 1'b1;
  assign pc_branch = pc + disp_ext[PC_WIDTH-1:0];

  // irq_take is only honoured from RUN, so entry and return can never
  // coincide; a simultaneous irq_take while active simply falls away.
  assign irq_entry = irq_take && !int_active;
  assign rti_act   = rti && int_active;

  // Next-state and datapath selection.
  always_comb begin
    state_next = state;
    flags_wr   = flags;
    flags_next = flags;
    epsr_next  = epsr;
    epc_next   = epc;
    pc_next    = pc;
    link_next  = link;
    instr_next = instr_en ? instr_in : instr;

    // Flag groups written independently; the result feeds both the flag
    // register and the shadow so same-cycle writes survive interrupt entry.
    if (cmp_f_en) begin
      flags_wr[1] = L_in;
      flags_wr[4] = N_in;
    end
    if (of_f_en) begin
      flags_wr[0] = C_in;
      flags_wr[2] = F_in;
    end
    if (z_f_en) begin
      flags_wr[3] = Z_in;
    end
    flags_next = flags_wr;

    // Link capture follows pc_en even on an entry cycle, but not on return
    // where pc_en is ignored.
    if (pc_en && link_en && !rti_act) begin
      link_next = pc_inc;
    end

    if (irq_entry) begin
      state_next = ST_IRQ;
      epc_next   = pc;
      epsr_next  = flags_wr;
      pc_next    = IRQ_PC;
      flags_next = '0;
    end else if (rti_act) begin
      state_next = ST_RUN;
      pc_next    = epc;
      flags_next = epsr;
    end else if (pc_en) begin
      case (pc_sel)
        2'b00:   pc_next = pc_inc;
        2'b01:   pc_next = pc_branch;
        2'b10:   pc_next = jump_addr;
        default: pc_next = pc;
      endcase
    end
  end

  // State register; reset dominates all other inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      flags <= '0;
      epsr  <= '0;
      pc    <= RESET_PC_V;
      link  <= '0;
      epc   <= '0;
      instr <= '0;
    end else begin
      state <= state_next;
      flags <= flags_next;
      epsr  <= epsr_next;
      pc    <= pc_next;
      link  <= link_next;
      epc   <= epc_next;
      instr <= instr_next;
    end
  end

endmodule
